ahb_lite_sram_slave: RTL and testbench



---
 rtl/ahb_lite_sram_slave.sv | 148 ++++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_sram_slave.sv
// AHB5-Lite subordinate: word-organised SRAM with byte-lane writes, a fixed number of
// data-phase wait states and a two-cycle ERROR response for illegal accesses.
module ahb_lite_sram_slave #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic        hready_in,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            xfer_q, xfer_d;
    logic            write_q, write_d;
    logic [1:0]      size_q, size_d;
    logic [1:0]      lo_q, lo_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            hreadyout_q, hreadyout_d;
    logic            hresp_q, hresp_d;
    logic [31:0]     mem_q [DEPTH];

    logic            accept;
    logic            addr_err;
    logic            complete;
    logic [3:0]      be;
    logic            unused_inputs;

    assign unused_inputs = ^{hburst, hprot, htrans[0]};

    // A new address phase is only taken while the current data phase is completing.
    assign accept   = hsel & hready_in & htrans[1] & hreadyout_q;
    assign addr_err = ({2'b00, haddr[31:2]} >= DEPTH)
                    | (hsize > 3'd2)
                    | ((hsize == 3'd1) & haddr[0])
                    | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));
    assign complete = xfer_q & hreadyout_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xfer_d  = xfer_q;
        write_d = write_q;
        size_d  = size_q;
        lo_d    = lo_q;
        idx_d   = idx_q;
        if (accept) begin
            write_d = hwrite;
            size_d  = hsize[1:0];
            lo_d    = haddr[1:0];
            idx_d   = haddr[AW+1:2];
            if (addr_err) begin
                state_d = StErr1;
                xfer_d  = 1'b0;
                cnt_d   = 4'd0;
            end else if (WAIT_STATES == 0) begin
                state_d = StIdle;
                xfer_d  = 1'b1;
                cnt_d   = 4'd0;
            end else begin
                state_d = StWait;
                xfer_d  = 1'b1;
                cnt_d   = 4'(WAIT_STATES);
            end
        end else begin
            case (state_q)
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_d = StIdle;
                        xfer_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                StErr1:  state_d = StErr2;
                default: begin
                    state_d = StIdle;
                    xfer_d  = 1'b0;
                end
            endcase
        end
        hreadyout_d = !((state_d == StErr1) || ((state_d == StWait) && (cnt_d != 4'd0)));
        hresp_d     = (state_d == StErr1) || (state_d == StErr2);
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            xfer_q      <= 1'b0;
            write_q     <= 1'b0;
            size_q      <= 2'd0;
            lo_q        <= 2'd0;
            idx_q       <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            xfer_q      <= xfer_d;
            write_q     <= write_d;
            size_q      <= size_d;
            lo_q        <= lo_d;
            idx_q       <= idx_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    always_comb begin
        case (size_q)
            2'd0:    be = 4'b0001 << lo_q;
            2'd1:    be = lo_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Commit on the completing edge; a following read sees the merged word next cycle.
    always_ff @(posedge hclk) begin
        if (!hreset && complete && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

    assign hrdata    = (complete && !write_q) ? mem_q[idx_q] : 32'h0;
    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench: pipelined vector table on a zero-wait instance, hand sequences on
// two wait-state instances for wait counting and reset-abort behaviour.
module tb_ahb_lite_sram_slave;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hsel0, hsel2, hsel3;
    logic        hrdy_block;
    logic [31:0] hrdata0, hrdata2, hrdata3;
    logic        hreadyout0, hreadyout2, hreadyout3;
    logic        hresp0, hresp2, hresp3;
    logic        hready_in0, hready_in2, hready_in3;

    int checks   = 0;
    int failures = 0;

    always #5 hclk = ~hclk;

    assign hready_in0 = hrdy_block ? 1'b0 : hreadyout0;
    assign hready_in2 = hreadyout2;
    assign hready_in3 = hreadyout3;

    ahb_lite_sram_slave #(.DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(3'd0), .hprot(4'd0),
        .hready_in(hready_in0), .hwdata(hwdata), .hrdata(hrdata0),
        .hreadyout(hreadyout0), .hresp(hresp0)
    );

    ahb_lite_sram_slave #(.DEPTH(1024), .WAIT_STATES(2)) u_dut2 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel2), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(3'd0), .hprot(4'd0),
        .hready_in(hready_in2), .hwdata(hwdata), .hrdata(hrdata2),
        .hreadyout(hreadyout2), .hresp(hresp2)
    );

    ahb_lite_sram_slave #(.DEPTH(1024), .WAIT_STATES(3)) u_dut3 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(3'd0), .hprot(4'd0),
        .hready_in(hready_in3), .hwdata(hwdata), .hrdata(hrdata3),
        .hreadyout(hreadyout3), .hresp(hresp3)
    );

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rdy;
        logic        resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic sel, input logic [1:0] trans, input logic wr,
                                input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wd, input logic rdy, input logic resp,
                                input logic [31:0] rdata);
        vec_t v;
        v.sel = sel; v.trans = trans; v.wr = wr; v.size = size; v.addr = addr;
        v.wd = wd; v.rdy = rdy; v.resp = resp; v.rdata = rdata;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    function automatic logic cur_rdy(input int d);
        case (d)
            0:       return hreadyout0;
            2:       return hreadyout2;
            default: return hreadyout3;
        endcase
    endfunction

    function automatic logic cur_resp(input int d);
        case (d)
            0:       return hresp0;
            2:       return hresp2;
            default: return hresp3;
        endcase
    endfunction

    function automatic logic [31:0] cur_rdata(input int d);
        case (d)
            0:       return hrdata0;
            2:       return hrdata2;
            default: return hrdata3;
        endcase
    endfunction

    task automatic set_sel(input int d);
        hsel0 = (d == 0);
        hsel2 = (d == 2);
        hsel3 = (d == 3);
    endtask

    // Single word transfer on a wait-state instance; returns read data seen in the
    // completing cycle and the number of hreadyout-low cycles before it.
    task automatic do_xfer(input int d, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd, output int lows);
        set_sel(d);
        htrans = 2'd2; hwrite = wr; hsize = 3'd2; haddr = addr;
        step();
        htrans = 2'd0; hwdata = wd;
        lows = 0;
        while (cur_rdy(d) == 1'b0 && lows < 20) begin
            lows++;
            step();
        end
        rd = cur_rdata(d);
        step();
    endtask

    initial begin
        logic [31:0] rd;
        int          lows;

        hreset = 1'b1; hrdy_block = 1'b0;
        haddr = '0; htrans = '0; hwrite = 1'b0; hsize = '0; hwdata = '0;
        set_sel(-1);
        step();
        step();
        hreset = 1'b0;
        step();
        for (int d = 0; d < 4; d++) begin
            if (d != 1) begin
                check($sformatf("reset_rdy_%0d", d), 32'(cur_rdy(d)), 32'd1);
                check($sformatf("reset_resp_%0d", d), 32'(cur_resp(d)), 32'd0);
                check($sformatf("reset_rdata_%0d", d), cur_rdata(d), 32'h0);
            end
        end

        // sel trans wr size addr wdata(prev beat) | rdy resp rdata
        add(1, 2, 1, 2, 32'h10,   32'h0,        1, 0, 32'h0);
        add(1, 2, 0, 2, 32'h10,   32'hDEADBEEF, 1, 0, 32'hDEADBEEF);
        add(1, 2, 1, 0, 32'h13,   32'h0,        1, 0, 32'h0);
        add(1, 2, 1, 1, 32'h10,   32'hAA000000, 1, 0, 32'h0);
        add(1, 2, 0, 2, 32'h10,   32'h00005566, 1, 0, 32'hAAAD5566);
        add(1, 2, 1, 2, 32'h20,   32'h0,        1, 0, 32'h0);
        add(1, 2, 0, 2, 32'h20,   32'h12345678, 1, 0, 32'h12345678);
        add(1, 0, 0, 2, 32'h20,   32'h0,        1, 0, 32'h0);
        add(1, 1, 0, 2, 32'h20,   32'h0,        1, 0, 32'h0);
        add(0, 2, 0, 2, 32'h20,   32'h0,        1, 0, 32'h0);
        add(1, 3, 0, 2, 32'h20,   32'h0,        1, 0, 32'h12345678);
        add(1, 2, 0, 1, 32'h22,   32'h0,        1, 0, 32'h12345678);
        add(1, 0, 0, 2, 32'h0,    32'h0,        1, 0, 32'h0);
        add(1, 2, 1, 2, 32'h0,    32'h0,        1, 0, 32'h0);
        add(1, 2, 0, 2, 32'h1000, 32'h01020304, 0, 1, 32'h0);
        add(1, 0, 0, 2, 32'h0,    32'h0,        1, 1, 32'h0);
        add(1, 2, 0, 2, 32'h10,   32'h0,        1, 0, 32'hAAAD5566);
        add(1, 2, 1, 2, 32'h02,   32'h0,        0, 1, 32'h0);
        add(1, 0, 0, 2, 32'h0,    32'hFFFFFFFF, 1, 1, 32'h0);
        add(1, 2, 1, 1, 32'h11,   32'hFFFFFFFF, 0, 1, 32'h0);
        add(1, 0, 0, 2, 32'h0,    32'hFFFFFFFF, 1, 1, 32'h0);
        add(1, 2, 0, 3, 32'h0,    32'hFFFFFFFF, 0, 1, 32'h0);
        add(1, 0, 0, 2, 32'h0,    32'h0,        1, 1, 32'h0);
        add(1, 2, 0, 2, 32'h0,    32'h0,        1, 0, 32'h01020304);
        add(1, 2, 0, 0, 32'h13,   32'h0,        1, 0, 32'hAAAD5566);
        add(1, 0, 0, 2, 32'h0,    32'h0,        1, 0, 32'h0);
        add(1, 2, 1, 2, 32'hFFC,  32'h0,        1, 0, 32'h0);
        add(1, 2, 0, 2, 32'hFFC,  32'hCAFEF00D, 1, 0, 32'hCAFEF00D);
        add(1, 0, 0, 2, 32'h0,    32'h0,        1, 0, 32'h0);

        foreach (vq[i]) begin
            set_sel(-1);
            hsel0 = vq[i].sel; htrans = vq[i].trans; hwrite = vq[i].wr;
            hsize = vq[i].size; haddr = vq[i].addr; hwdata = vq[i].wd;
            step();
            check($sformatf("v%0d_rdy", i), 32'(hreadyout0), 32'(vq[i].rdy));
            check($sformatf("v%0d_resp", i), 32'(hresp0), 32'(vq[i].resp));
            check($sformatf("v%0d_rdata", i), hrdata0, vq[i].rdata);
        end

        // Address phase held off by the bus must not be taken.
        hrdy_block = 1'b1;
        hsel0 = 1'b1; htrans = 2'd2; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h10;
        step();
        check("hready_low_rdata", hrdata0, 32'h0);
        check("hready_low_rdy", 32'(hreadyout0), 32'd1);
        hrdy_block = 1'b0; htrans = 2'd0;
        step();
        check("hready_low_after", hrdata0, 32'h0);

        // Two wait states.
        do_xfer(2, 1'b1, 32'h10, 32'h11223344, rd, lows);
        check("ws2_write_lows", 32'(lows), 32'd2);
        do_xfer(2, 1'b0, 32'h10, 32'h0, rd, lows);
        check("ws2_read_lows", 32'(lows), 32'd2);
        check("ws2_read_data", rd, 32'h11223344);
        check("ws2_idle_rdy", 32'(hreadyout2), 32'd1);
        check("ws2_idle_resp", 32'(hresp2), 32'd0);
        check("ws2_idle_rdata", hrdata2, 32'h0);

        // Three wait states, reset in the second wait cycle of a write.
        do_xfer(3, 1'b1, 32'h30, 32'hA5A5A5A5, rd, lows);
        check("ws3_write_lows", 32'(lows), 32'd3);
        set_sel(3);
        htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h30;
        step();
        check("ws3_wait1_rdy", 32'(hreadyout3), 32'd0);
        htrans = 2'd0; hwdata = 32'h5A5A5A5A;
        step();
        check("ws3_wait2_rdy", 32'(hreadyout3), 32'd0);
        hreset = 1'b1;
        step();
        hreset = 1'b0;
        check("ws3_rst_rdy", 32'(hreadyout3), 32'd1);
        check("ws3_rst_resp", 32'(hresp3), 32'd0);
        step();
        do_xfer(3, 1'b0, 32'h30, 32'h0, rd, lows);
        check("ws3_read_lows", 32'(lows), 32'd3);
        check("ws3_read_data", rd, 32'hA5A5A5A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
